// File: rtl/rx_merge.sv
// rx_merge: merges two lane streams through per-lane FIFOs, VC0 first, round-robin on ties.
// Optional macro RX_WORD_COUNT_EN adds per-VC delivered-word counters cnt_vc0/cnt_vc1.

module rx_merge #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic              init,
  input  logic [DATA_W-1:0] data_in_l0,
  input  logic              valid_l0,
  input  logic [DATA_W-1:0] data_in_l1,
  input  logic              valid_l1,
  input  logic [PTR_W:0]    thr_low,
  input  logic [PTR_W:0]    thr_high,
  input  logic              pop_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              empty_out,
  output logic              pause_l0,
  output logic              pause_l1,
  output logic              err_l0,
  output logic              err_l1,
  output logic [2:0]        state_out
`ifdef RX_WORD_COUNT_EN
  ,
  output logic [7:0]        cnt_vc0,
  output logic [7:0]        cnt_vc1
`endif
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam logic [PTR_W:0]   FULL_CNT     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT      = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   THR_LOW_RST  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   THR_HIGH_RST = (PTR_W+1)'(DEPTH-1);
  localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);

  state_t state, next_state;

  logic [DATA_W-1:0] mem        [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr     [2];
  logic [PTR_W-1:0]  rd_ptr     [2];
  logic [PTR_W:0]    count      [2];
  logic [PTR_W:0]    next_count [2];
  logic [DATA_W-1:0] lane_data  [2];
  logic [DATA_W-1:0] head       [2];

  logic [1:0]        lane_valid;
  logic [1:0]        nonempty;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        err_set;
  logic [1:0]        pause;
  logic [1:0]        pause_next;
  logic [1:0]        err;
  logic [PTR_W:0]    thr_low_q;
  logic [PTR_W:0]    thr_high_q;
  logic              rr_last;
  logic              grant_any;
  logic              grant_lane;
  logic              datapath_on;
  logic              enter_init;
  logic [DATA_W-1:0] grant_word;

  assign lane_data[0] = data_in_l0;
  assign lane_data[1] = data_in_l1;
  assign lane_valid   = {valid_l1, valid_l0};
  assign datapath_on  = (state == ST_IDLE) || (state == ST_ACTIVE) || (state == ST_ERROR);
  assign enter_init   = (next_state == ST_INIT) && (state != ST_INIT);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nonempty[i] = (count[i] != '0);
      head[i]     = mem[i][rd_ptr[i]];
    end
  end

  // Arbitration: a VC0 head (bit5=0) wins; equal VCs go to the lane not granted last.
  always_comb begin
    grant_any  = 1'b0;
    grant_lane = 1'b0;
    if (pop_out && datapath_on) begin
      if (nonempty[0] && nonempty[1]) begin
        grant_any = 1'b1;
        if (head[0][DATA_W-1] != head[1][DATA_W-1])
          grant_lane = head[0][DATA_W-1];
        else
          grant_lane = ~rr_last;
      end else if (nonempty[0]) begin
        grant_any  = 1'b1;
        grant_lane = 1'b0;
      end else if (nonempty[1]) begin
        grant_any  = 1'b1;
        grant_lane = 1'b1;
      end
    end
  end

  assign pop[0]     = grant_any & ~grant_lane;
  assign pop[1]     = grant_any & grant_lane;
  assign grant_word = grant_lane ? head[1] : head[0];

  // A push into a full lane only fits when that same lane is drained this cycle.
  always_comb begin
    push    = '0;
    err_set = '0;
    for (int i = 0; i < 2; i++) begin
      next_count[i] = count[i];
      push[i]    = lane_valid[i] & datapath_on & ((count[i] != FULL_CNT) | pop[i]);
      err_set[i] = (lane_valid[i] & datapath_on & (count[i] == FULL_CNT) & ~pop[i])
                 | (pop[i] & (count[i] == '0));
      case ({push[i], pop[i]})
        2'b10:   next_count[i] = count[i] + ONE_CNT;
        2'b01:   next_count[i] = count[i] - ONE_CNT;
        default: next_count[i] = count[i];
      endcase
    end
  end

  always_comb begin
    pause_next = pause;
    for (int i = 0; i < 2; i++) begin
      if (thr_low_q >= thr_high_q)
        pause_next[i] = (next_count[i] >= thr_high_q);
      else if (next_count[i] >= thr_high_q)
        pause_next[i] = 1'b1;
      else if (next_count[i] <= thr_low_q)
        pause_next[i] = 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET: next_state = ST_INIT;
      ST_INIT: begin
        if (!init) next_state = ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE: begin
        if (init)
          next_state = ST_INIT;
        else if (|err_set)
          next_state = ST_ERROR;
        else if ((next_count[0] != '0) || (next_count[1] != '0))
          next_state = ST_ACTIVE;
        else
          next_state = ST_IDLE;
      end
      ST_ERROR: begin
        if (init) next_state = ST_INIT;
      end
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L)
      state <= ST_RESET;
    else
      state <= next_state;
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < DEPTH; j++)
          mem[i][j] <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= lane_data[i];
          wr_ptr[i]         <= wr_ptr[i] + PTR_ONE;
        end
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
        count[i] <= next_count[i];
      end
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      empty_out <= 1'b1;
      rr_last   <= 1'b1;
    end else begin
      valid_out <= grant_any;
      empty_out <= (next_count[0] == '0) && (next_count[1] == '0);
      if (grant_any) begin
        data_out <= grant_word;
        rr_last  <= grant_lane;
      end
    end
  end

  // Errors stay set until the block is re-initialised.
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      pause      <= '0;
      err        <= '0;
      thr_low_q  <= THR_LOW_RST;
      thr_high_q <= THR_HIGH_RST;
    end else begin
      pause <= pause_next;
      err   <= enter_init ? 2'b00 : (err | err_set);
      if (state == ST_INIT) begin
        thr_low_q  <= thr_low;
        thr_high_q <= thr_high;
      end
    end
  end

`ifdef RX_WORD_COUNT_EN
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (enter_init) begin
      cnt_vc0 <= '0;
      cnt_vc1 <= '0;
    end else if (grant_any) begin
      if (grant_word[DATA_W-1])
        cnt_vc1 <= cnt_vc1 + 8'd1;
      else
        cnt_vc0 <= cnt_vc0 + 8'd1;
    end
  end
`endif

  assign pause_l0  = pause[0];
  assign pause_l1  = pause[1];
  assign err_l0    = err[0];
  assign err_l1    = err[1];
  assign state_out = state;

endmodule

// File: tb/tb_rx_merge.sv
// tb_rx_merge: directed scenarios plus random traffic for rx_merge, checked against a queue-based model.
// Define RX_WORD_COUNT_EN to also exercise the delivered-word counters.

module tb_rx_merge;

  localparam int DATA_W = 6;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;

  logic              clk;
  logic              RESET_L;
  logic              init;
  logic [DATA_W-1:0] data_in_l0;
  logic              valid_l0;
  logic [DATA_W-1:0] data_in_l1;
  logic              valid_l1;
  logic [PTR_W:0]    thr_low;
  logic [PTR_W:0]    thr_high;
  logic              pop_out;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              empty_out;
  logic              pause_l0;
  logic              pause_l1;
  logic              err_l0;
  logic              err_l1;
  logic [2:0]        state_out;
`ifdef RX_WORD_COUNT_EN
  logic [7:0]        cnt_vc0;
  logic [7:0]        cnt_vc1;
  int                m_c0;
  int                m_c1;
`endif

  int vec_count;
  int miscompares;

  // Reference model: plain queues per lane plus the architectural flags.
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         m_state;
  logic [5:0] m_data;
  logic       m_valid, m_empty, m_p0, m_p1, m_e0, m_e1, m_rr;
  int         m_tl, m_th;

  rx_merge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .RESET_L    (RESET_L),
    .init       (init),
    .data_in_l0 (data_in_l0),
    .valid_l0   (valid_l0),
    .data_in_l1 (data_in_l1),
    .valid_l1   (valid_l1),
    .thr_low    (thr_low),
    .thr_high   (thr_high),
    .pop_out    (pop_out),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .empty_out  (empty_out),
    .pause_l0   (pause_l0),
    .pause_l1   (pause_l1),
    .err_l0     (err_l0),
    .err_l1     (err_l1),
    .state_out  (state_out)
`ifdef RX_WORD_COUNT_EN
    ,
    .cnt_vc0    (cnt_vc0),
    .cnt_vc1    (cnt_vc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_state = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_empty = 1'b1;
    m_p0    = 1'b0;
    m_p1    = 1'b0;
    m_e0    = 1'b0;
    m_e1    = 1'b0;
    m_rr    = 1'b1;
    m_tl    = 1;
    m_th    = DEPTH - 1;
`ifdef RX_WORD_COUNT_EN
    m_c0 = 0;
    m_c1 = 0;
`endif
  endtask

  function automatic logic next_pause(input logic cur, input int n, input int lo, input int hi);
    if (lo >= hi) return (n >= hi);
    if (n >= hi)  return 1'b1;
    if (n <= lo)  return 1'b0;
    return cur;
  endfunction

  task automatic model_step(input logic i_init, input logic i_v0, input logic [5:0] i_d0,
                            input logic i_v1, input logic [5:0] i_d1, input logic i_pop);
    logic       run;
    int         grant;
    logic [5:0] w, h0, h1;
    logic       s0, s1;
    int         nst;
    run   = (m_state == 2) || (m_state == 3) || (m_state == 4);
    grant = -1;
    w     = m_data;
    h0    = '0;
    h1    = '0;
    if (i_pop && run) begin
      if (q0.size() > 0 && q1.size() > 0) begin
        h0 = q0[0];
        h1 = q1[0];
        if (h0[5] != h1[5]) grant = h0[5] ? 1 : 0;
        else                grant = m_rr ? 0 : 1;
      end else if (q0.size() > 0) grant = 0;
      else if (q1.size() > 0)     grant = 1;
    end
    s0 = i_v0 && run && (q0.size() == DEPTH) && (grant != 0);
    s1 = i_v1 && run && (q1.size() == DEPTH) && (grant != 1);
    if (grant == 0) w = q0.pop_front();
    if (grant == 1) w = q1.pop_front();
    if (i_v0 && run && !s0) q0.push_back(i_d0);
    if (i_v1 && run && !s1) q1.push_back(i_d1);

    if (m_state == 0)                        nst = 1;
    else if (i_init)                         nst = 1;
    else if (m_state == 1)                   nst = 2;
    else if (m_state == 4)                   nst = 4;
    else if (s0 || s1)                       nst = 4;
    else if (q0.size() > 0 || q1.size() > 0) nst = 3;
    else                                     nst = 2;

    m_valid = (grant >= 0);
    if (grant >= 0) begin
      m_data = w;
      m_rr   = (grant == 1);
`ifdef RX_WORD_COUNT_EN
      if (w[5]) m_c1 = (m_c1 + 1) % 256;
      else      m_c0 = (m_c0 + 1) % 256;
`endif
    end
    if (nst == 1 && m_state != 1) begin
      m_e0 = 1'b0;
      m_e1 = 1'b0;
`ifdef RX_WORD_COUNT_EN
      m_c0 = 0;
      m_c1 = 0;
`endif
    end else begin
      m_e0 = m_e0 | s0;
      m_e1 = m_e1 | s1;
    end
    m_p0 = next_pause(m_p0, q0.size(), m_tl, m_th);
    m_p1 = next_pause(m_p1, q1.size(), m_tl, m_th);
    if (m_state == 1) begin
      m_tl = int'(thr_low);
      m_th = int'(thr_high);
    end
    m_empty = (q0.size() == 0) && (q1.size() == 0);
    m_state = nst;
  endtask

  task automatic compare_all();
    checkOutput("data_out",  32'(data_out),  32'(m_data));
    checkOutput("valid_out", 32'(valid_out), 32'(m_valid));
    checkOutput("empty_out", 32'(empty_out), 32'(m_empty));
    checkOutput("pause_l0",  32'(pause_l0),  32'(m_p0));
    checkOutput("pause_l1",  32'(pause_l1),  32'(m_p1));
    checkOutput("err_l0",    32'(err_l0),    32'(m_e0));
    checkOutput("err_l1",    32'(err_l1),    32'(m_e1));
    checkOutput("state_out", 32'(state_out), 32'(m_state));
`ifdef RX_WORD_COUNT_EN
    checkOutput("cnt_vc0",   32'(cnt_vc0),   32'(m_c0));
    checkOutput("cnt_vc1",   32'(cnt_vc1),   32'(m_c1));
`endif
  endtask

  // One clock of stimulus: drive, advance the model, then sample just after the edge.
  task automatic applyStimulus(input logic i_init, input logic i_v0, input logic [5:0] i_d0,
                               input logic i_v1, input logic [5:0] i_d1, input logic i_pop);
    init       = i_init;
    valid_l0   = i_v0;
    data_in_l0 = i_d0;
    valid_l1   = i_v1;
    data_in_l1 = i_d1;
    pop_out    = i_pop;
    model_step(i_init, i_v0, i_d0, i_v1, i_d1, i_pop);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_data"},  32'(data_out),  32'h0);
    checkOutput({tag, "_valid"}, 32'(valid_out), 32'h0);
    checkOutput({tag, "_empty"}, 32'(empty_out), 32'h1);
    checkOutput({tag, "_p0"},    32'(pause_l0),  32'h0);
    checkOutput({tag, "_p1"},    32'(pause_l1),  32'h0);
    checkOutput({tag, "_e0"},    32'(err_l0),    32'h0);
    checkOutput({tag, "_e1"},    32'(err_l1),    32'h0);
    checkOutput({tag, "_state"}, 32'(state_out), 32'h0);
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    RESET_L     = 1'b0;
    init        = 1'b0;
    valid_l0    = 1'b0;
    valid_l1    = 1'b0;
    data_in_l0  = '0;
    data_in_l1  = '0;
    pop_out     = 1'b0;
    thr_low     = 3'd1;
    thr_high    = 3'd3;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    RESET_L = 1'b1;

    // Bring-up: RESET -> INIT, hold init, then release to IDLE.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("bringup_state", 32'(state_out), 32'd2);

    // Single word through lane 0.
    applyStimulus(0, 1, 6'h05, 0, 0, 0);
    checkOutput("t1_active", 32'(state_out), 32'd3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t1_data",  32'(data_out),  32'h05);
    checkOutput("t1_valid", 32'(valid_out), 32'h1);
    checkOutput("t1_idle",  32'(state_out), 32'd2);
    checkOutput("t1_empty", 32'(empty_out), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1_hold", 32'(data_out), 32'h05);

    // VC0 on lane 1 beats VC1 on lane 0.
    applyStimulus(0, 1, 6'h25, 1, 6'h15, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_first", 32'(data_out), 32'h15);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t2_second", 32'(data_out), 32'h25);

    // Make lane 1 the last grant, then alternate between equal-VC heads.
    applyStimulus(0, 0, 0, 1, 6'h1A, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 6'h01, 1, 6'h11, 0);
    applyStimulus(0, 1, 6'h02, 0, 0, 1);
    checkOutput("t3_pop1", 32'(data_out), 32'h01);
    applyStimulus(0, 0, 0, 1, 6'h12, 1);
    checkOutput("t3_pop2", 32'(data_out), 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_pop3", 32'(data_out), 32'h02);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t3_pop4", 32'(data_out), 32'h12);

    // Pause hysteresis on lane 0 with low=1, high=3.
    applyStimulus(0, 1, 6'h03, 0, 0, 0);
    applyStimulus(0, 1, 6'h04, 0, 0, 0);
    checkOutput("t4_p_at2", 32'(pause_l0), 32'h0);
    applyStimulus(0, 1, 6'h06, 0, 0, 0);
    checkOutput("t4_p_at3", 32'(pause_l0), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_p_hold", 32'(pause_l0), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_p_rel", 32'(pause_l0), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Overflow lane 1, drain it from ERROR, recover with init.
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 0, 1, 6'(6'h21 + i), 0);
    checkOutput("t5_err", 32'(err_l1), 32'h1);
    checkOutput("t5_state", 32'(state_out), 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("t5_drain", 32'(data_out), 32'(6'h21 + i));
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t5_init_state", 32'(state_out), 32'd1);
    checkOutput("t5_init_err", 32'(err_l1), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Asynchronous reset with words buffered.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 6'(6'h08 + i), 0, 0, 0);
    #2;
    RESET_L = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(negedge clk);
    RESET_L = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t6_nopop", 32'(valid_out), 32'h0);

`ifdef RX_WORD_COUNT_EN
    // Exactly 256 VC0 deliveries from a cleared counter.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'h07, 0, 0, 0);
    for (int i = 0; i < 255; i++)
      applyStimulus(0, 1, 6'h07, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("cnt_wrap_vc0", 32'(cnt_vc0), 32'h0);
    checkOutput("cnt_wrap_vc1", 32'(cnt_vc1), 32'h0);
`endif

    // Random traffic with occasional re-init and threshold changes.
    for (int c = 0; c < 1500; c++) begin
      logic r_init;
      r_init = ($urandom_range(0, 63) == 0) || ((m_state == 4) && ($urandom_range(0, 7) == 0));
      if (r_init) begin
        thr_low  = 3'($urandom_range(0, 4));
        thr_high = 3'($urandom_range(0, 4));
      end
      applyStimulus(r_init,
                    1'($urandom_range(0, 1)), 6'($urandom),
                    1'($urandom_range(0, 1)), 6'($urandom),
                    ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
